// File: rtl/iopmp_pkg.sv
// Shared types for the IOPMP deny responder: TL-UL payloads, error config and record.
package iopmp_pkg;

    localparam int unsigned SourceWidth  = 8;
    localparam int unsigned AddrWidth    = 32;
    localparam int unsigned DataWidth    = 32;
    localparam int unsigned MaskWidth    = DataWidth / 8;
    localparam int unsigned SizeWidth    = 2;
    localparam int unsigned SinkWidth    = 1;
    localparam int unsigned UserWidth    = 14;
    localparam int unsigned ErrAddrWidth = 34;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    localparam logic [UserWidth-1:0] TlDUserDefault = '0;

    typedef struct packed {
        logic                   a_valid;
        tl_a_op_e               a_opcode;
        logic [2:0]             a_param;
        logic [SizeWidth-1:0]   a_size;
        logic [SourceWidth-1:0] a_source;
        logic [AddrWidth-1:0]   a_address;
        logic [MaskWidth-1:0]   a_mask;
        logic [DataWidth-1:0]   a_data;
        logic [UserWidth-1:0]   a_user;
        logic                   d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic                   d_valid;
        tl_d_op_e               d_opcode;
        logic [2:0]             d_param;
        logic [SizeWidth-1:0]   d_size;
        logic [SourceWidth-1:0] d_source;
        logic [SinkWidth-1:0]   d_sink;
        logic [DataWidth-1:0]   d_data;
        logic [UserWidth-1:0]   d_user;
        logic                   d_error;
        logic                   a_ready;
    } tl_d2h_t;

    // rre/rwe: respond with success instead of a bus error for denied reads/writes.
    typedef struct packed {
        logic l;
        logic ie;
        logic rie;
        logic rre;
        logic rwe;
    } err_cfg;

    typedef enum logic [1:0] {
        IOPMP_ACC_NONE  = 2'd0,
        IOPMP_ACC_READ  = 2'd1,
        IOPMP_ACC_WRITE = 2'd2,
        IOPMP_ACC_EXEC  = 2'd3
    } iopmp_req_e;

    typedef enum logic {
        RSP_IDLE   = 1'b0,
        RSP_ACTIVE = 1'b1
    } rsp_state_e;

    typedef struct packed {
        logic [ErrAddrWidth-1:0] addr;
        logic [SourceWidth-1:0]  rrid;
        iopmp_req_e              access;
    } err_record_t;

endpackage

// File: rtl/iopmp_err_record.sv
// Error record: captures the first denied beat, flags later denials as overflow until cleared.
module iopmp_err_record
    import iopmp_pkg::*;
#(
    parameter int unsigned RridWidth = SourceWidth
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    capture,
    input  logic                    clr,
    input  logic [AddrWidth-1:0]    cap_addr,
    input  logic [RridWidth-1:0]    cap_rrid,
    input  iopmp_req_e              cap_access,
    output logic                    err_valid_o,
    output logic                    err_overflow_o,
    output logic [ErrAddrWidth-1:0] err_addr_o,
    output logic [RridWidth-1:0]    err_rrid_o,
    output iopmp_req_e              err_access_o
);

    localparam err_record_t RecReset = '{addr: '0, rrid: '0, access: IOPMP_ACC_READ};

    err_record_t rec;
    err_record_t new_rec;

    assign new_rec = '{addr:   ErrAddrWidth'(cap_addr),
                       rrid:   SourceWidth'(cap_rrid),
                       access: cap_access};

    // A clear coinciding with a capture hands the record straight to the new beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            rec            <= RecReset;
            err_valid_o    <= 1'b0;
            err_overflow_o <= 1'b0;
        end else if (clr) begin
            rec            <= capture ? new_rec : RecReset;
            err_valid_o    <= capture;
            err_overflow_o <= 1'b0;
        end else if (capture) begin
            if (!err_valid_o) begin
                rec         <= new_rec;
                err_valid_o <= 1'b1;
            end else begin
                err_overflow_o <= 1'b1;
            end
        end
    end

    assign err_addr_o   = rec.addr;
    assign err_rrid_o   = RridWidth'(rec.rrid);
    assign err_access_o = rec.access;

endmodule

// File: rtl/iopmp_deny_responder.sv
// Answers IOPMP-denied TL-UL beats with an error (or suppressed) response and logs the denial.
module iopmp_deny_responder
    import iopmp_pkg::*;
#(
    parameter int unsigned RridWidth = SourceWidth
) (
    input  logic                    clk,
    input  logic                    rst,
    input  tl_h2d_t                 tl_h_i,
    output tl_d2h_t                 tl_h_o,
    input  logic [RridWidth-1:0]    rrid_i,
    input  err_cfg                  ERR_CFG,
    output logic                    err_valid_o,
    output logic [ErrAddrWidth-1:0] err_addr_o,
    output logic [RridWidth-1:0]    err_rrid_o,
    output iopmp_req_e              err_access_o,
    output logic                    err_overflow_o,
    input  logic                    err_clr_i
);

    rsp_state_e             state;
    tl_d_op_e               d_opcode_q;
    logic                   d_error_q;
    logic [DataWidth-1:0]   d_data_q;
    logic [SourceWidth-1:0] d_source_q;
    logic [SizeWidth-1:0]   d_size_q;

    logic                   a_hs;
    logic                   d_hs;
    tl_d_op_e               rsp_opcode;
    logic                   rsp_error;
    logic [DataWidth-1:0]   rsp_data;
    iopmp_req_e             rsp_access;

    assign a_hs = tl_h_i.a_valid && (state == RSP_IDLE);
    assign d_hs = tl_h_i.d_ready && (state == RSP_ACTIVE);

    // Response decode; ERR_CFG only matters at the instant it is latched.
    always_comb begin
        rsp_opcode = AccessAck;
        rsp_error  = 1'b1;
        rsp_data   = '0;
        rsp_access = IOPMP_ACC_READ;
        case (tl_h_i.a_opcode)
            Get: begin
                rsp_opcode = AccessAckData;
                rsp_error  = !ERR_CFG.rre;
                rsp_data   = ERR_CFG.rre ? '0 : {DataWidth{1'b1}};
            end
            PutFullData, PutPartialData: begin
                rsp_error  = !ERR_CFG.rwe;
                rsp_access = IOPMP_ACC_WRITE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RSP_IDLE;
            d_opcode_q <= AccessAck;
            d_error_q  <= 1'b0;
            d_data_q   <= '0;
            d_source_q <= '0;
            d_size_q   <= '0;
        end else begin
            case (state)
                RSP_IDLE: begin
                    if (a_hs) begin
                        state      <= RSP_ACTIVE;
                        d_opcode_q <= rsp_opcode;
                        d_error_q  <= rsp_error;
                        d_data_q   <= rsp_data;
                        d_source_q <= tl_h_i.a_source;
                        d_size_q   <= tl_h_i.a_size;
                    end
                end
                RSP_ACTIVE: begin
                    if (d_hs) state <= RSP_IDLE;
                end
                default: state <= RSP_IDLE;
            endcase
        end
    end

    always_comb begin
        tl_h_o          = '0;
        tl_h_o.a_ready  = (state == RSP_IDLE);
        tl_h_o.d_valid  = (state == RSP_ACTIVE);
        tl_h_o.d_opcode = d_opcode_q;
        tl_h_o.d_param  = '0;
        tl_h_o.d_size   = d_size_q;
        tl_h_o.d_source = d_source_q;
        tl_h_o.d_sink   = '0;
        tl_h_o.d_data   = d_data_q;
        tl_h_o.d_user   = TlDUserDefault;
        tl_h_o.d_error  = d_error_q;
    end

    iopmp_err_record #(
        .RridWidth(RridWidth)
    ) u_err_record (
        .clk           (clk),
        .rst           (rst),
        .capture       (a_hs),
        .clr           (err_clr_i),
        .cap_addr      (tl_h_i.a_address),
        .cap_rrid      (rrid_i),
        .cap_access    (rsp_access),
        .err_valid_o   (err_valid_o),
        .err_overflow_o(err_overflow_o),
        .err_addr_o    (err_addr_o),
        .err_rrid_o    (err_rrid_o),
        .err_access_o  (err_access_o)
    );

    // Payload and config fields a deny response never looks at.
    logic unused_inputs;
    assign unused_inputs = ^{tl_h_i.a_param, tl_h_i.a_mask, tl_h_i.a_data, tl_h_i.a_user,
                             ERR_CFG.l, ERR_CFG.ie, ERR_CFG.rie};

endmodule

// File: tb/tb_iopmp_deny_responder.sv
// Scoreboard bench for iopmp_deny_responder: directed scenarios followed by randomized traffic.
module tb_iopmp_deny_responder;
    import iopmp_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    tl_h2d_t    a_drv;
    tl_h2d_t    h;
    tl_d2h_t    d;
    logic [SourceWidth-1:0] rrid;
    err_cfg     cfg;
    logic       d_ready;
    logic       err_clr;
    logic       err_valid;
    logic       err_overflow;
    logic [ErrAddrWidth-1:0] err_addr;
    logic [SourceWidth-1:0]  err_rrid;
    iopmp_req_e err_access;

    int   ready_mode = 2;    // 0 random, 1 held low, 2 held high
    logic rand_en    = 1'b0;
    logic clr_force  = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [2:0]  op;
        logic        err;
        logic [31:0] data;
        logic [7:0]  src;
        logic [1:0]  size;
    } exp_t;

    exp_t exp_q[$];

    // Reference state: response pending, and the error record contents.
    logic        m_dv    = 1'b0;
    logic        m_valid = 1'b0;
    logic        m_ovf   = 1'b0;
    logic [33:0] m_addr  = '0;
    logic [7:0]  m_rrid  = '0;
    logic [1:0]  m_acc   = 2'd1;

    always #5 clk = ~clk;

    always_comb begin
        h         = a_drv;
        h.d_ready = d_ready;
    end

    iopmp_deny_responder #(.RridWidth(SourceWidth)) dut (
        .clk           (clk),
        .rst           (rst),
        .tl_h_i        (h),
        .tl_h_o        (d),
        .rrid_i        (rrid),
        .ERR_CFG       (cfg),
        .err_valid_o   (err_valid),
        .err_addr_o    (err_addr),
        .err_rrid_o    (err_rrid),
        .err_access_o  (err_access),
        .err_overflow_o(err_overflow),
        .err_clr_i     (err_clr)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model_rsp(input logic [2:0] op, input logic rre, input logic rwe,
                                       input logic [7:0] src, input logic [1:0] size);
        exp_t e;
        e.src  = src;
        e.size = size;
        e.data = 32'h0;
        if (op == 3'h4) begin
            e.op   = 3'h1;
            e.err  = !rre;
            e.data = rre ? 32'h0 : 32'hFFFF_FFFF;
        end else if (op == 3'h0 || op == 3'h1) begin
            e.op  = 3'h0;
            e.err = !rwe;
        end else begin
            e.op  = 3'h0;
            e.err = 1'b1;
        end
        return e;
    endfunction

    // Monitor: compare against the reference, then advance it by the coming edge.
    always @(negedge clk) begin
        exp_t e;
        logic a_hs_m;
        chk("d_valid", d.d_valid, m_dv);
        chk("a_ready", d.a_ready, !m_dv);
        if (d.d_valid) begin
            if (exp_q.size() == 0) begin
                chk("d_unexpected_q", exp_q.size(), 1);
            end else begin
                e = exp_q[0];
                chk("d_opcode", d.d_opcode, e.op);
                chk("d_error",  d.d_error,  e.err);
                chk("d_data",   d.d_data,   e.data);
                chk("d_source", d.d_source, e.src);
                chk("d_size",   d.d_size,   e.size);
                chk("d_param",  d.d_param,  0);
                chk("d_sink",   d.d_sink,   0);
                chk("d_user",   d.d_user,   0);
            end
        end
        chk("err_valid",    err_valid,    m_valid);
        chk("err_overflow", err_overflow, m_ovf);
        if (m_valid) begin
            chk("err_addr",   err_addr,   m_addr);
            chk("err_rrid",   err_rrid,   m_rrid);
            chk("err_access", err_access, m_acc);
        end

        if (rst) begin
            m_dv = 1'b0; m_valid = 1'b0; m_ovf = 1'b0;
            m_addr = '0; m_rrid = '0; m_acc = 2'd1;
            exp_q.delete();
        end else begin
            a_hs_m = h.a_valid && !m_dv;
            if (a_hs_m) begin
                exp_q.push_back(model_rsp(h.a_opcode, cfg.rre, cfg.rwe, h.a_source, h.a_size));
                m_dv = 1'b1;
            end else if (m_dv && d_ready) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                m_dv = 1'b0;
            end
            if (a_hs_m && (err_clr || !m_valid)) begin
                m_valid = 1'b1;
                m_ovf   = 1'b0;
                m_addr  = {2'b00, h.a_address};
                m_rrid  = rrid;
                m_acc   = (h.a_opcode == 3'h0 || h.a_opcode == 3'h1) ? 2'd2 : 2'd1;
            end else if (err_clr) begin
                m_valid = 1'b0;
                m_ovf   = 1'b0;
            end else if (a_hs_m) begin
                m_ovf = 1'b1;
            end
        end
    end

    // Background drivers for d_ready and err_clr, offset from the edge.
    initial begin
        d_ready = 1'b1;
        err_clr = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       d_ready = ($urandom_range(0, 3) != 0);
                1:       d_ready = 1'b0;
                default: d_ready = 1'b1;
            endcase
            err_clr = rand_en ? ($urandom_range(0, 9) == 0) : clr_force;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] op, input logic [31:0] addr, input logic [7:0] src,
                        input logic [7:0] rid, input logic rre, input logic rwe,
                        input logic with_clr);
        logic ok;
        a_drv.a_valid   = 1'b1;
        a_drv.a_opcode  = tl_a_op_e'(op);
        a_drv.a_address = addr;
        a_drv.a_source  = src;
        a_drv.a_size    = 2'($urandom_range(0, 2));
        a_drv.a_data    = $urandom;
        a_drv.a_mask    = 4'hF;
        rrid            = rid;
        cfg.l           = 1'($urandom_range(0, 1));
        cfg.ie          = 1'($urandom_range(0, 1));
        cfg.rie         = 1'($urandom_range(0, 1));
        cfg.rre         = rre;
        cfg.rwe         = rwe;
        if (with_clr) clr_force = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 64 && !ok; n++) begin
            @(negedge clk);
            ok = d.a_ready;
        end
        chk("a_accept", ok, 1);
        @(posedge clk);
        #1;
        a_drv.a_valid = 1'b0;
        clr_force     = 1'b0;
        // Scramble config and rrid: a pending response must not follow them.
        cfg.rre = 1'($urandom_range(0, 1));
        cfg.rwe = 1'($urandom_range(0, 1));
        rrid    = 8'($urandom);
    endtask

    task automatic clr_pulse();
        clr_force = 1'b1;
        step(1);
        clr_force = 1'b0;
        step(1);
    endtask

    task automatic wait_idle();
        logic idle;
        idle = 1'b0;
        for (int n = 0; n < 200 && !idle; n++) begin
            @(negedge clk);
            idle = !d.d_valid && (exp_q.size() == 0);
        end
        chk("drain", idle, 1);
        step(1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        a_drv = '0;
        rrid  = '0;
        cfg   = '0;
        step(3);
        @(negedge clk);
        chk("rst_d_data",   d.d_data,   0);
        chk("rst_d_source", d.d_source, 0);
        chk("rst_d_error",  d.d_error,  0);
        chk("rst_err_addr", err_addr,   0);
        chk("rst_err_rrid", err_rrid,   0);
        chk("rst_err_acc",  err_access, 1);
        step(1);
        rst = 1'b0;
        step(1);

        // Denied Get with rre=0: error response and read capture.
        send(3'h4, 32'h8000_0010, 8'd3, 8'd1, 1'b0, 1'b0, 1'b0);
        wait_idle();
        chk("dir_addr", err_addr, 34'h0_8000_0010);
        chk("dir_rrid", err_rrid, 1);
        clr_pulse();

        // PutFullData with rwe=1: suppressed, still recorded as write.
        send(3'h0, 32'h0000_1234, 8'd5, 8'd2, 1'b0, 1'b1, 1'b0);
        wait_idle();
        chk("dir_wr_acc", err_access, 2);
        clr_pulse();

        // Backpressure: response must hold for five cycles.
        ready_mode = 1;
        send(3'h4, 32'h0000_0040, 8'd7, 8'd4, 1'b1, 1'b0, 1'b0);
        step(5);
        ready_mode = 2;
        wait_idle();
        clr_pulse();

        // Two denials: first one kept, overflow set, then cleared.
        send(3'h1, 32'h0000_0100, 8'd1, 8'd9, 1'b0, 1'b0, 1'b0);
        send(3'h4, 32'h0000_0200, 8'd2, 8'd8, 1'b0, 1'b0, 1'b0);
        wait_idle();
        chk("dir_ovf_keep", err_addr, 34'h0_0000_0100);
        clr_pulse();

        // Overflowed record, then clear coinciding with a new beat.
        send(3'h4, 32'h0000_0300, 8'd1, 8'd1, 1'b0, 1'b0, 1'b0);
        send(3'h4, 32'h0000_0400, 8'd1, 8'd2, 1'b0, 1'b0, 1'b0);
        wait_idle();
        send(3'h0, 32'h0000_0500, 8'd6, 8'd3, 1'b0, 1'b0, 1'b1);
        wait_idle();
        chk("dir_clr_hs_addr", err_addr, 34'h0_0000_0500);
        clr_pulse();

        // Reset while a response is pending, then an unknown opcode.
        ready_mode = 1;
        send(3'h4, 32'h0000_0600, 8'd4, 8'd5, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        ready_mode = 2;
        send(3'h5, 32'h0000_0700, 8'd2, 8'd6, 1'b1, 1'b1, 1'b0);
        wait_idle();
        clr_pulse();

        // Randomized traffic with random backpressure and clears.
        rand_en    = 1'b1;
        ready_mode = 0;
        repeat (200) begin
            logic [2:0] op;
            case ($urandom_range(0, 3))
                0:       op = 3'h4;
                1:       op = 3'h0;
                2:       op = 3'h1;
                default: op = 3'($urandom);
            endcase
            step($urandom_range(0, 2));
            send(op, $urandom, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'b0);
        end
        rand_en    = 1'b0;
        ready_mode = 2;
        wait_idle();
        step(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/iopmp_deny_responder.md
IOPMP_DENY_RESPONDER -- requirements
Module: iopmp_deny_responder

Interface
REQ-001 SHALL have parameter RridWidth, default SourceWidth: width of the captured requester ID.
REQ-002 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port tl_h_i  input  tl_h2d_t  A channel and d_ready from the request handler, carrying denied beats only.
REQ-005 SHALL have port tl_h_o  output  tl_d2h_t  a_ready and D-channel response to the request handler.
REQ-006 SHALL have port rrid_i  input  RridWidth  requester ID of the current A beat.
REQ-007 SHALL have port ERR_CFG  input  iopmp_pkg::err_cfg  error config; only the rre and rwe fields are used.
REQ-008 SHALL have port err_valid_o  output  1  error record holds a valid capture.
REQ-009 SHALL have port err_addr_o  output  34  captured address; bits [33:32] = 0.
REQ-010 SHALL have port err_rrid_o  output  RridWidth  captured requester ID.
REQ-011 SHALL have port err_access_o  output  iopmp_req_e  captured access: IOPMP_ACC_READ or IOPMP_ACC_WRITE.
REQ-012 SHALL have port err_overflow_o  output  1  sticky flag: a denial arrived while the record was valid.
REQ-013 SHALL have port err_clr_i  input  1  one-cycle pulse that clears the record and the overflow flag.

Function
REQ-014 SHALL implement a two-state FSM: RSP_IDLE and RSP_ACTIVE.
REQ-015 In RSP_IDLE: a_ready=1, d_valid=0. In RSP_ACTIVE: a_ready=0, d_valid=1.
REQ-016 RSP_IDLE -> RSP_ACTIVE on a_valid && a_ready; latch a_opcode, a_source, a_size, a_address, rrid_i.
REQ-017 RSP_ACTIVE -> RSP_IDLE on d_valid && d_ready; d_valid SHALL stay high and D fields stable until then.
REQ-018 Latency: d_valid rises exactly one cycle after the A handshake. Peak throughput is one beat per 2 cycles.
REQ-019 Get SHALL produce d_opcode AccessAckData.
- ERR_CFG.rre=1: d_error=0, d_data=0.
- ERR_CFG.rre=0: d_error=1, d_data=32'hFFFF_FFFF.
REQ-020 PutFullData and PutPartialData SHALL produce d_opcode AccessAck with d_error=!ERR_CFG.rwe and d_data=0.
REQ-021 Any other opcode SHALL produce AccessAck with d_error=1, regardless of ERR_CFG; its access type is recorded as READ.
REQ-022 ERR_CFG SHALL be sampled at the A handshake; later changes SHALL NOT alter a pending response.
REQ-023 D fields: d_source=latched a_source, d_size=latched a_size, d_param=0, d_sink=0, d_user=default.
REQ-024 Error record capture on each A handshake:
- err_valid_o=0: load addr/rrid/access and set err_valid_o next cycle.
- err_valid_o=1: keep the old record and set err_overflow_o.
REQ-025 err_clr_i alone SHALL clear err_valid_o and err_overflow_o next cycle.
REQ-026 err_clr_i in the same cycle as a handshake: the new beat is loaded, err_valid_o=1, err_overflow_o=0.
REQ-027 Record capture SHALL be independent of ERR_CFG; suppressed (success) responses are still recorded.

Reset
REQ-028 On rst: FSM=RSP_IDLE, a_ready=1, d_valid=0, all D fields 0, err_valid_o=0, err_overflow_o=0, err_addr_o=0, err_rrid_o=0, err_access_o=IOPMP_ACC_READ.
REQ-029 rst asserted in RSP_ACTIVE SHALL drop d_valid at the next edge; the pending response is discarded, not replayed.

Structure
REQ-030 State enum rsp_state_e {RSP_IDLE, RSP_ACTIVE} and struct err_record_t {addr, rrid, access} SHALL live in iopmp_pkg.
REQ-031 Capture, overflow and clear logic SHALL be one sub-module, iopmp_err_record; the FSM and D channel stay in the top.

Verification
REQ-032 Get @0x8000_0010, source 3, rrid 1, rre=0 -> one cycle later AccessAckData, d_error=1, d_data=FFFF_FFFF, d_source=3; err_addr_o=0x0_8000_0010, err_rrid_o=1, READ.
REQ-033 PutFullData, rwe=1 -> AccessAck, d_error=0; err_valid_o=1, access=WRITE.
REQ-034 d_ready held low 5 cycles, then high -> d_valid and fields stable for all 5 cycles, a_ready=0 throughout; returns to idle after the handshake.
REQ-035 Two denials without clear -> record keeps the first beat, err_overflow_o=1; err_clr_i pulse -> both 0.
REQ-036 err_clr_i coincident with an A handshake -> record holds the new beat, err_valid_o=1, err_overflow_o=0.
REQ-037 rst in RSP_ACTIVE -> d_valid=0 and a_ready=1 next cycle; opcode 3'h5 afterwards -> AccessAck with d_error=1.
